// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake,
// optional accumulator chaining and a saturating completed-op counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (f)
            3'd0:    r = x & z;
            3'd1:    r = x | z;
            3'd2:    r = ~(x & z);
            3'd3:    r = ~(x | z);
            3'd4:    r = x ^ z;
            3'd5:    r = ~(x ^ z);
            3'd6:    r = ~x;
            3'd7:    r = ~z;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic             s1_valid_q,   s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,       s1_a_d;
    logic [WIDTH-1:0] s1_b_q,       s1_b_d;
    logic [2:0]       s1_op_q,      s1_op_d;
    logic             s1_acc_en_q,  s1_acc_en_d;
    logic             s1_acc_clr_q, s1_acc_clr_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] y_q,          y_d;
    logic             y_zero_q,     y_zero_d;
    logic             y_parity_q,   y_parity_d;
    logic [WIDTH-1:0] acc_q,        acc_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic             stall_s;
    logic [WIDTH-1:0] operand_s;
    logic [WIDTH-1:0] result_s;

    // Stall, operand select and gate evaluation for the op sitting in S1
    always_comb begin
        stall_s   = out_valid_q && !out_ready;
        operand_s = s1_acc_en_q ? (s1_acc_clr_q ? {WIDTH{1'b0}} : acc_q) : s1_a_q;
        result_s  = gate_f(s1_op_q, operand_s, s1_b_q);
    end

    // Next-state: the whole pipe advances together or holds together
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_acc_en_d  = s1_acc_en_q;
        s1_acc_clr_d = s1_acc_clr_q;
        out_valid_d  = out_valid_q;
        y_d          = y_q;
        y_zero_d     = y_zero_q;
        y_parity_d   = y_parity_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;

        if (!stall_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d        = result_s;
                y_zero_d   = (result_s == {WIDTH{1'b0}});
                y_parity_d = parity_f(result_s);
                // Acc is written as the op enters S2, so the next acc op reads it directly
                if (s1_acc_en_q) begin
                    acc_d = result_s;
                end else begin
                    acc_d = acc_q;
                end
            end else begin
                y_d = y_q;
            end
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d       = a;
                s1_b_d       = b;
                s1_op_d      = op;
                s1_acc_en_d  = acc_en;
                s1_acc_clr_d = acc_clr;
            end else begin
                s1_a_d = s1_a_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (out_valid_q && out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= {WIDTH{1'b0}};
            s1_b_q       <= {WIDTH{1'b0}};
            s1_op_q      <= 3'd0;
            s1_acc_en_q  <= 1'b0;
            s1_acc_clr_q <= 1'b0;
            out_valid_q  <= 1'b0;
            y_q          <= {WIDTH{1'b0}};
            y_zero_q     <= 1'b0;
            y_parity_q   <= 1'b0;
            acc_q        <= {WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_acc_en_q  <= s1_acc_en_d;
            s1_acc_clr_q <= s1_acc_clr_d;
            out_valid_q  <= out_valid_d;
            y_q          <= y_d;
            y_zero_q     <= y_zero_d;
            y_parity_q   <= y_parity_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_zero    = y_zero_q;
    assign y_parity  = y_parity_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: truth-table reference model with an
// expected-result queue, directed scenarios pinned by literals, and random traffic.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] op = 3'd0;
    logic       acc_en = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       y_zero;
    logic       y_parity;
    logic [7:0] op_count;

    logic       rdy_rand = 1'b0;
    logic       rdy_force = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Per-op truth tables indexed by {a_bit, b_bit}
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                           4'b0110, 4'b1001, 4'b0011, 4'b0101};
    logic [7:0] lit1 [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'h33};

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       p;
    } exp_t;

    exp_t       exp_q [$];
    int         acc_cyc_q [$];
    logic [7:0] macc = 8'h00;
    int         mcnt = 0;
    logic [7:0] got_y [$];
    logic       got_z [$];
    logic       got_p [$];
    int         got_lat [$];

    logic_gate_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_zero(y_zero),
        .y_parity(y_parity), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] model_gate(input logic [2:0] f, input logic [7:0] x,
                                              input logic [7:0] z);
        logic [7:0] r;
        logic [3:0] t;
        t = tt[f];
        for (int i = 0; i < 8; i++) r[i] = t[{x[i], z[i]}];
        return r;
    endfunction

    // Reference model and compare process, evaluated mid-cycle
    initial begin
        logic       prev_stall;
        logic [7:0] prev_y;
        logic [7:0] opa;
        exp_t       e;
        int         c0;
        prev_stall = 1'b0;
        prev_y = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                acc_cyc_q.delete();
                macc = 8'h00;
                mcnt = 0;
                prev_stall = 1'b0;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_op_count", 32'(op_count), 32'd0);
                check("rst_y", 32'(y), 32'd0);
            end else begin
                check("op_count", 32'(op_count), 32'(mcnt));
                check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_y", 32'(y), 32'(prev_y));
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("y", 32'(y), 32'(e.y));
                        check("y_zero", 32'(y_zero), 32'(e.z));
                        check("y_parity", 32'(y_parity), 32'(e.p));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            c0 = acc_cyc_q.pop_front();
                            got_y.push_back(y);
                            got_z.push_back(y_zero);
                            got_p.push_back(y_parity);
                            got_lat.push_back(cyc - c0);
                            if (mcnt < 255) mcnt++;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_y = y;
                if (in_valid && in_ready) begin
                    opa = acc_en ? (acc_clr ? 8'h00 : macc) : a;
                    e.y = model_gate(op, opa, b);
                    e.z = (e.y == 8'h00);
                    e.p = ^e.y;
                    if (acc_en) macc = e.y;
                    exp_q.push_back(e);
                    acc_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                        input logic ten, input logic tclr);
        int t;
        a = ta; b = tb_v; op = top; acc_en = ten; acc_clr = tclr; in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        got_y.delete(); got_z.delete(); got_p.delete(); got_lat.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Every gate on F0/CC, back-to-back
        clr_log();
        for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0);
        drain();
        check("t1_count", 32'(got_y.size()), 32'd8);
        if (got_y.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_y", 32'(got_y[i]), 32'(lit1[i]));
                check("t1_par", 32'(got_p[i]), 32'd0);
                check("t1_lat", 32'(got_lat[i]), 32'd2);
            end
        end

        // Accumulator chain
        clr_log();
        send(8'h00, 8'h0F, 3'd1, 1'b1, 1'b1);
        send(8'h00, 8'hFF, 3'd4, 1'b1, 1'b0);
        drain();
        check("t2_count", 32'(got_y.size()), 32'd2);
        if (got_y.size() == 2) begin
            check("t2_y0", 32'(got_y[0]), 32'h0F);
            check("t2_y1", 32'(got_y[1]), 32'hF0);
        end

        // Backpressure on the first result for four cycles
        clr_log();
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                send(8'h12, 8'h34, 3'd0, 1'b0, 1'b0);
                send(8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
                send(8'h12, 8'h34, 3'd4, 1'b0, 1'b0);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                check("t3_valid", 32'(out_valid), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    check("t3_in_ready", 32'(in_ready), 32'd0);
                    check("t3_y_frozen", 32'(y), 32'h10);
                    if (i < 3) @(negedge clk);
                end
                rdy_force = 1'b1;
            end
        join
        drain();
        check("t3_count", 32'(got_y.size()), 32'd3);
        if (got_y.size() == 3) begin
            check("t3_y0", 32'(got_y[0]), 32'h10);
            check("t3_y1", 32'(got_y[1]), 32'h36);
            check("t3_y2", 32'(got_y[2]), 32'h26);
        end

        // Flag corners
        clr_log();
        send(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
        send(8'h00, 8'hFE, 3'd7, 1'b0, 1'b0);
        drain();
        check("t4_count", 32'(got_y.size()), 32'd2);
        if (got_y.size() == 2) begin
            check("t4_y0", 32'(got_y[0]), 32'h00);
            check("t4_z0", 32'(got_z[0]), 32'd1);
            check("t4_p0", 32'(got_p[0]), 32'd0);
            check("t4_y1", 32'(got_y[1]), 32'h01);
            check("t4_z1", 32'(got_z[1]), 32'd0);
            check("t4_p1", 32'(got_p[1]), 32'd1);
        end

        // Counter saturation: 254, then 6 more
        do_reset();
        for (int i = 0; i < 254; i++)
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        drain();
        check("t5_cnt_fe", 32'(op_count), 32'hFE);
        for (int i = 0; i < 6; i++)
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        drain();
        check("t5_cnt_ff", 32'(op_count), 32'hFF);

        // Reset with two ops in flight and acc = 5A
        send(8'h00, 8'h5A, 3'd1, 1'b1, 1'b1);
        drain();
        send(8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        send(8'h33, 8'h44, 3'd4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clr_log();
        send(8'h00, 8'h03, 3'd4, 1'b1, 1'b0);
        drain();
        check("t6_count", 32'(got_y.size()), 32'd1);
        if (got_y.size() == 1) check("t6_acc_cleared", 32'(got_y[0]), 32'h03);

        // Random traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
